// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the PC/IR stage: branch funct3 codes, the
// architectural NOP and the fetch-handshake state encoding.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_ir_unit_if.sv
// Bundle between the multicycle control FSM / datapath (master) and the
// PC/IR stage (slave).
interface pc_ir_unit_if;

    logic        ir_write;
    logic        pc_update;
    logic        branch;
    logic [2:0]  funct3;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic [31:0] result;
    logic [31:0] read_data;
    logic        mem_ready;

    logic [31:0] pc;
    logic [31:0] old_pc;
    logic [31:0] instr;
    logic        pc_write;
    logic        stall;
    logic        fault;
    logic [31:0] instret;

    modport master (
        output ir_write, pc_update, branch, funct3,
        output zero, negative, carry, overflow,
        output result, read_data, mem_ready,
        input  pc, old_pc, instr, pc_write, stall, fault, instret
    );

    modport slave (
        input  ir_write, pc_update, branch, funct3,
        input  zero, negative, carry, overflow,
        input  result, read_data, mem_ready,
        output pc, old_pc, instr, pc_write, stall, fault, instret
    );

endinterface

// File: rtl/pc_ir_unit_branch_cond.sv
// Branch-taken decision from funct3 and the flags of the A-B compare.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry,
    input  logic       overflow,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = negative ^ overflow;
            F3_BGE:  taken = ~(negative ^ overflow);
            // carry is the no-borrow flag of A-B, so A<B unsigned is !carry
            F3_BLTU: taken = ~carry;
            F3_BGEU: taken = carry;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / OldPC / IR stage with pending-fetch handshake and misalign fault.
// Optional retired-fetch counter enabled by defining PC_IR_INSTRET_EN.
module pc_ir_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    pc_ir_unit_if.slave  bus
);

    import riscv_pkg::fetch_state_t;
    import riscv_pkg::F_IDLE;
    import riscv_pkg::F_WAIT;

    fetch_state_t state_reg;
    fetch_state_t state_next;

    logic [31:0] pc_reg;
    logic [31:0] old_pc_reg;
    logic [31:0] instr_reg;
    logic        fault_reg;

    logic taken;
    logic write_req;
    logic misalign;
    logic pc_write;
    logic fetch_start;
    logic fetch_done;
    logic protocol_err;

    branch_cond u_branch_cond (
        .funct3   (bus.funct3),
        .zero     (bus.zero),
        .negative (bus.negative),
        .carry    (bus.carry),
        .overflow (bus.overflow),
        .taken    (taken)
    );

    assign misalign     = (bus.result[1:0] != 2'b00);
    assign write_req    = bus.pc_update | (bus.branch & taken);
    assign pc_write     = write_req & ~misalign;
    assign fetch_start  = (state_reg == F_IDLE) & bus.ir_write;
    assign fetch_done   = (state_reg == F_IDLE) ? (bus.ir_write & bus.mem_ready)
                                                : bus.mem_ready;
    assign protocol_err = (state_reg == F_WAIT) & bus.ir_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= F_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A stray ir_write while waiting only faults; mem_ready still completes
    // the outstanding fetch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            F_IDLE:  if (bus.ir_write && !bus.mem_ready) state_next = F_WAIT;
            F_WAIT:  if (bus.mem_ready) state_next = F_IDLE;
            default: state_next = F_IDLE;
        endcase
    end

    always_comb begin
        bus.stall = (state_reg == F_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            old_pc_reg <= RESET_PC;
            instr_reg  <= NOP_INSTR;
            fault_reg  <= 1'b0;
        end else begin
            if (pc_write) begin
                pc_reg <= bus.result;
            end
            // pc_reg here is the pre-update value even if pc_write fires too
            if (fetch_start) begin
                old_pc_reg <= pc_reg;
            end
            if (fetch_done) begin
                instr_reg <= bus.read_data;
            end
            if ((write_req && misalign) || protocol_err) begin
                fault_reg <= 1'b1;
            end
        end
    end

`ifdef PC_IR_INSTRET_EN
    logic [31:0] instret_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_reg <= 32'd0;
        end else if (fetch_done) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign bus.instret = instret_reg;
`else
    assign bus.instret = 32'd0;
`endif

    assign bus.pc       = pc_reg;
    assign bus.old_pc   = old_pc_reg;
    assign bus.instr    = instr_reg;
    assign bus.pc_write = pc_write;
    assign bus.fault    = fault_reg;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Vector-table bench for pc_ir_unit with an expectation queue drained after
// each clock edge.
module tb_pc_ir_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pc_ir_unit_if bus ();

    pc_ir_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        irw;
        logic        pcu;
        logic        br;
        logic [2:0]  f3;
        logic [3:0]  flags;   // {zero, negative, carry, overflow}
        logic [31:0] res;
        logic [31:0] rd;
        logic        rdy;
        logic        exp_pw;
        logic [31:0] exp_pc;
        logic [31:0] exp_old;
        logic [31:0] exp_instr;
        logic        exp_stall;
        logic        exp_fault;
        logic        ld;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        tbl[$];
    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_ret = 32'd0;
    int          stall_cycles;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic vec_t mk(
        input string n, input logic rst, input logic irw, input logic pcu,
        input logic br, input logic [2:0] f3, input logic [3:0] flags,
        input logic [31:0] res, input logic [31:0] rd, input logic rdy,
        input logic pw, input logic [31:0] pc, input logic [31:0] old,
        input logic [31:0] ins, input logic st, input logic flt, input logic ld);
        vec_t v;
        v.name = n; v.rst = rst; v.irw = irw; v.pcu = pcu; v.br = br;
        v.f3 = f3; v.flags = flags; v.res = res; v.rd = rd; v.rdy = rdy;
        v.exp_pw = pw; v.exp_pc = pc; v.exp_old = old; v.exp_instr = ins;
        v.exp_stall = st; v.exp_fault = flt; v.ld = ld;
        return v;
    endfunction

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset         = v.rst;
        bus.ir_write  = v.irw;
        bus.pc_update = v.pcu;
        bus.branch    = v.br;
        bus.funct3    = v.f3;
        {bus.zero, bus.negative, bus.carry, bus.overflow} = v.flags;
        bus.result    = v.res;
        bus.read_data = v.rd;
        bus.mem_ready = v.rdy;
        #1;
        chk({v.name, ".pc_write"}, {31'd0, bus.pc_write}, {31'd0, v.exp_pw});
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.rst) exp_ret = 32'd0;
`ifdef PC_IR_INSTRET_EN
        else if (e.ld) exp_ret = exp_ret + 32'd1;
`endif
        chk({e.name, ".pc"},     bus.pc,     e.exp_pc);
        chk({e.name, ".old_pc"}, bus.old_pc, e.exp_old);
        chk({e.name, ".instr"},  bus.instr,  e.exp_instr);
        chk({e.name, ".stall"},  {31'd0, bus.stall}, {31'd0, e.exp_stall});
        chk({e.name, ".fault"},  {31'd0, bus.fault}, {31'd0, e.exp_fault});
        chk({e.name, ".instret"}, bus.instret, exp_ret);
        $display("[TB] %-14s pc=%h old_pc=%h instr=%h stall=%0b fault=%0b instret=%0d",
                 e.name, bus.pc, bus.old_pc, bus.instr, bus.stall, bus.fault, bus.instret);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ir_write = 1'b0; bus.pc_update = 1'b0; bus.branch = 1'b0;
        bus.funct3 = 3'b000; bus.zero = 1'b0; bus.negative = 1'b0;
        bus.carry = 1'b0; bus.overflow = 1'b0; bus.result = 32'd0;
        bus.read_data = 32'd0; bus.mem_ready = 1'b0;

        //        name         rst irw pcu br  f3      zncv     result        read_data     rdy pw  pc            old_pc        instr         st  flt ld
        tbl.push_back(mk("reset1",    1, 0, 0, 0, 3'b000, 4'b0000, 32'h0,        32'h0,        0,  0, 32'h0,        32'h0,        NOP,          0, 0, 0));
        tbl.push_back(mk("reset2",    1, 0, 0, 0, 3'b000, 4'b0000, 32'h0,        32'h0,        0,  0, 32'h0,        32'h0,        NOP,          0, 0, 0));
        tbl.push_back(mk("fetch1",    0, 1, 1, 0, 3'b000, 4'b0000, 32'h4,        32'h00500093, 1,  1, 32'h4,        32'h0,        32'h00500093, 0, 0, 1));
        tbl.push_back(mk("idle",      0, 0, 0, 0, 3'b000, 4'b0000, 32'h8,        32'h0,        0,  0, 32'h4,        32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("beq_t",     0, 0, 0, 1, 3'b000, 4'b1000, 32'h20,       32'h0,        0,  1, 32'h20,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("bne_nt",    0, 0, 0, 1, 3'b001, 4'b1000, 32'h30,       32'h0,        0,  0, 32'h20,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("blt_t",     0, 0, 0, 1, 3'b100, 4'b0100, 32'h40,       32'h0,        0,  1, 32'h40,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("bge_nt",    0, 0, 0, 1, 3'b101, 4'b0100, 32'h80,       32'h0,        0,  0, 32'h40,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("bltu_t",    0, 0, 0, 1, 3'b110, 4'b0000, 32'h44,       32'h0,        0,  1, 32'h44,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("bgeu_nt",   0, 0, 0, 1, 3'b111, 4'b0000, 32'h48,       32'h0,        0,  0, 32'h44,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("f3_010",    0, 0, 0, 1, 3'b010, 4'b1010, 32'h50,       32'h0,        0,  0, 32'h44,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("bge_t_ov",  0, 0, 0, 1, 3'b101, 4'b0101, 32'h58,       32'h0,        0,  1, 32'h58,       32'h0,        32'h00500093, 0, 0, 0));
        tbl.push_back(mk("fetch2",    0, 1, 1, 0, 3'b000, 4'b0000, 32'h5C,       32'h11111111, 1,  1, 32'h5C,       32'h58,       32'h11111111, 0, 0, 1));
        tbl.push_back(mk("nt_misal",  0, 0, 0, 1, 3'b001, 4'b1000, 32'h42,       32'h0,        0,  0, 32'h5C,       32'h58,       32'h11111111, 0, 0, 0));
        tbl.push_back(mk("bgeu_t",    0, 0, 0, 1, 3'b111, 4'b0010, 32'h60,       32'h0,        0,  1, 32'h60,       32'h58,       32'h11111111, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Multi-cycle fetch: three stall cycles, PC+4 commits on the fetch edge.
        stall_cycles = 0;
        step(mk("wait_start", 0, 1, 1, 0, 3'b000, 4'b0000, 32'h64, 32'h0,        0, 1, 32'h64, 32'h60, 32'h11111111, 1, 0, 0));
        stall_cycles += int'(bus.stall);
        step(mk("wait_1",     0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h0,        0, 0, 32'h64, 32'h60, 32'h11111111, 1, 0, 0));
        stall_cycles += int'(bus.stall);
        step(mk("wait_2",     0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h0,        0, 0, 32'h64, 32'h60, 32'h11111111, 1, 0, 0));
        stall_cycles += int'(bus.stall);
        step(mk("wait_done",  0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'hFE000EE3, 1, 0, 32'h64, 32'h60, 32'hFE000EE3, 0, 0, 1));
        stall_cycles += int'(bus.stall);
        chk("stall_cycles", stall_cycles, 32'd3);
        step(mk("rdy_no_irw", 0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h22222222, 1, 0, 32'h64, 32'h60, 32'hFE000EE3, 0, 0, 0));

        // Misaligned PC write: fault sticks, pc holds, later aligned writes still work.
        step(mk("misal_pcu",  0, 0, 1, 0, 3'b000, 4'b0000, 32'h42, 32'h0, 0, 0, 32'h64, 32'h60, 32'hFE000EE3, 0, 1, 0));
        step(mk("fault_hold", 0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h0, 0, 0, 32'h64, 32'h60, 32'hFE000EE3, 0, 1, 0));
        step(mk("aligned",    0, 0, 1, 0, 3'b000, 4'b0000, 32'h70, 32'h0, 0, 1, 32'h70, 32'h60, 32'hFE000EE3, 0, 1, 0));

        // ir_write during a pending fetch, then reset discards the fetch.
        step(mk("reset3",     1, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0, NOP, 0, 0, 0));
        step(mk("fetch_wait", 0, 1, 1, 0, 3'b000, 4'b0000, 32'h10, 32'h0,        0, 1, 32'h10, 32'h0, NOP, 1, 0, 0));
        step(mk("irw_in_wait",0, 1, 0, 0, 3'b000, 4'b0000, 32'h0,  32'h0,        0, 0, 32'h10, 32'h0, NOP, 1, 1, 0));
        step(mk("reset_mid",  1, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'hDEADBEEF, 1, 0, 32'h0,  32'h0, NOP, 0, 0, 0));
        step(mk("post_reset", 0, 0, 0, 0, 3'b000, 4'b0000, 32'h0,  32'hDEADBEEF, 1, 0, 32'h0,  32'h0, NOP, 0, 0, 0));
        step(mk("br_misal",   0, 0, 0, 1, 3'b000, 4'b1000, 32'h3,  32'h0,        0, 0, 32'h0,  32'h0, NOP, 0, 1, 0));

        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Program-counter and instruction-register stage directly downstream of the multicycle main control FSM.
- Consumes the FSM's IRWrite, PCUpdate and Branch strobes plus ALU flags.
- Owns the architectural PC, OldPC and the instruction register (IR).
- Evaluates branch conditions, absorbs variable instruction-memory latency through a pending-fetch handshake, and flags misaligned PC writes.

Parameters:
- RESET_PC, 32'h0000_0000, PC and OldPC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- ir_write, input, 1, FSM fetch strobe; single-cycle pulse.
- pc_update, input, 1, FSM unconditional PC-write request.
- branch, input, 1, FSM branch-evaluate strobe.
- funct3, input, 3, instr[14:12] of the current IR.
- zero, negative, carry, overflow, input, 1 each, ALU flags from the A−B compare.
- result, input, 32, result-mux value, used as the next PC.
- read_data, input, 32, memory read data.
- mem_ready, input, 1, read_data valid this cycle.
- pc, output, 32, current PC.
- old_pc, output, 32, PC of the instruction held in IR.
- instr, output, 32, instruction register.
- pc_write, output, 1, combinational: a PC write is committed this cycle.
- stall, output, 1, fetch pending; the FSM must hold in decode.
- fault, output, 1, sticky error flag.
- instret, output, 32, retired-fetch count (optional feature).

Behaviour:
- Reset values:
  - pc = RESET_PC, old_pc = RESET_PC, instr = NOP_INSTR.
  - stall = 0, fault = 0, instret = 0.
  - Fetch FSM returns to F_IDLE.
  - Reset wins over every concurrent event, including a pending fetch, which is discarded.
- Branch taken, by funct3:
  - 000 beq: zero.
  - 001 bne: !zero.
  - 100 blt: negative^overflow.
  - 101 bge: !(negative^overflow).
  - 110 bltu: !carry.
  - 111 bgeu: carry.
  - 010 and 011: never taken.
- pc_write = (pc_update | (branch & taken)) & !misalign, where misalign = (result[1:0] != 2'b00).
- On pc_write, pc <= result on the next edge.
- A write request with misalign set:
  - sets fault;
  - leaves pc unchanged;
  - pc_write stays 0.
- Fetch FSM has two states, F_IDLE and F_WAIT.
  - F_IDLE, ir_write & mem_ready: instr <= read_data, old_pc <= pc; stay F_IDLE. Single-cycle fetch.
  - F_IDLE, ir_write & !mem_ready: old_pc <= pc; go to F_WAIT.
  - F_WAIT: stall = 1.
  - F_WAIT, mem_ready: instr <= read_data; go to F_IDLE. stall deasserts the following cycle.
  - F_WAIT, ir_write: protocol error; fault set, captured old_pc kept, state stays F_WAIT.
  - PC update on the fetch edge is independent of the FSM state, so PC+4 commits even while waiting.
- old_pc always captures the pre-update pc, even when pc_write occurs on the same edge.
- fault is sticky; only reset clears it.
- stall is registered-state derived (stall = state==F_WAIT), never combinational from mem_ready.

Optional Feature:
- Macro: PC_IR_INSTRET_EN.
- Defined: instret increments by 1 (wrap modulo 2^32) on every edge where instr is loaded from read_data.
- Not defined: instret is driven constant 0 and no counter flops exist.

Decomposition:
- Shared package riscv_pkg holds:
  - branch funct3 constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU);
  - NOP_INSTR default;
  - fetch-state encoding (F_IDLE=1'b0, F_WAIT=1'b1).
- One combinational sub-module, branch_cond: funct3 plus the four flags in, taken out.
- PC, IR and fetch FSM stay in pc_ir_unit.

Test Plan:
1. Reset held 2 cycles -> pc=0, old_pc=0, instr=32'h00000013, stall=0, fault=0.
2. ir_write+pc_update, mem_ready=1, read_data=32'h00500093, result=4 -> next cycle instr=32'h00500093, old_pc=0, pc=4, stall=0.
3. ir_write, mem_ready=0 for 3 cycles then 1 with read_data=32'hFE000EE3 -> stall high exactly 3 cycles after fetch, instr loaded on ready edge, old_pc=pre-fetch pc.
4. branch=1, funct3=3'b100, negative=1, overflow=0, result=32'h40 -> pc_write=1, pc=32'h40; repeat with funct3=3'b101 -> pc unchanged.
5. pc_update=1, result=32'h0000_0042 -> pc unchanged, fault=1, remains 1 until reset.
6. ir_write while in F_WAIT -> fault=1, old_pc unchanged; reset asserted mid-wait -> state F_IDLE, stall=0, instr=NOP next cycle.
